pool2x2_stream: RTL and testbench

Streaming 2x2, stride-1 pooling stage placed directly downstream of the 3x3 convolution engine. It accepts the raster-ordered 5x5 OFM stream (36-bit unsigned words, one per valid cycle) and emits a raster-ordered 4x4 pooled map. Pooling is max by default; average is available as a compile option. It uses a one-row-plus-one line buffer and a 2-stage reduction pipeline, so no full-frame storage is needed.

---
 rtl/pool_pkg.sv | 13 +
 rtl/pool_reduce4.sv | 85 ++++++++
 rtl/pool2x2_stream.sv | 84 ++++++++
 tb/tb_pool2x2_stream.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared constants for the 2x2 stride-1 pooling stage.
//   POOL_DATA_W  : default sample width (unsigned)
//   POOL_IN_DIM  : default input map height/width
//   POOL_OUT_DIM : pooled map height/width
//   POOL_CNT_W   : width of the row/column position counters
package pool_pkg;

  localparam int unsigned POOL_DATA_W  = 36;
  localparam int unsigned POOL_IN_DIM  = 5;
  localparam int unsigned POOL_OUT_DIM = POOL_IN_DIM - 1;
  localparam int unsigned POOL_CNT_W   = $clog2(POOL_IN_DIM);

endpackage

// File: rtl/pool_reduce4.sv
// Two-stage registered reduction of a 2x2 window to one sample.
// Build option: define POOL_AVG_EN for floor-of-mean pooling; default is max pooling.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_valid, i_last  window present this cycle / window is the last of its frame
//   i_a..i_d         window samples (upleft, up, left, current)
//   o_valid, o_last  registered result valid / last-of-frame pulse
//   o_data           registered result, 0 when o_valid is low
module pool_reduce4 #(
  parameter int unsigned DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  input  logic [DATA_W-1:0] i_d,
  output logic              o_valid,
  output logic              o_last,
  output logic [DATA_W-1:0] o_data
);

`ifdef POOL_AVG_EN
  // Pair sums need one carry bit; the final sum needs two.
  localparam int unsigned S1W = DATA_W + 1;
`else
  localparam int unsigned S1W = DATA_W;
`endif

  logic [S1W-1:0]    w_p0, w_p1;
  logic [S1W-1:0]    r_p0, r_p1;
  logic              r_s1_valid, r_s1_last;
  logic [DATA_W-1:0] w_res;

`ifdef POOL_AVG_EN
  logic [DATA_W+1:0] w_sum;

  always_comb begin
    w_p0  = {1'b0, i_a} + {1'b0, i_b};
    w_p1  = {1'b0, i_c} + {1'b0, i_d};
    w_sum = {1'b0, r_p0} + {1'b0, r_p1};
    // Mean of four DATA_W values always fits in DATA_W.
    w_res = DATA_W'(w_sum >> 2);
  end
`else
  always_comb begin
    w_p0  = (i_a > i_b) ? i_a : i_b;
    w_p1  = (i_c > i_d) ? i_c : i_d;
    w_res = (r_p0 > r_p1) ? r_p0 : r_p1;
  end
`endif

  // Stage 1: pairwise reduction. Valid bits advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_last  <= i_valid & i_last;
      if (i_valid) begin
        r_p0 <= w_p0;
        r_p1 <= w_p1;
      end
    end
  end

  // Stage 2: final reduction; data forced to 0 on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= r_s1_valid;
      o_last  <= r_s1_last;
      o_data  <= r_s1_valid ? w_res : '0;
    end
  end

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-1 pooling of a raster-ordered IN_DIM x IN_DIM map into an
// (IN_DIM-1) x (IN_DIM-1) map. Max pooling by default; define POOL_AVG_EN for average.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     In_OFM carries a sample this cycle
//   In_OFM       input sample, row-major order
//   out_valid    Out_Pool carries a pooled result
//   Out_Pool     pooled result, 0 when out_valid is low
//   frame_done   pulse with the last pooled result of a frame
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = POOL_DATA_W,
  parameter int unsigned IN_DIM = POOL_IN_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_OFM,
  output logic              out_valid,
  output logic [DATA_W-1:0] Out_Pool,
  output logic              frame_done
);

  localparam int unsigned CntW = $clog2(IN_DIM);

  logic [CntW-1:0]   r_col, r_row;
  // r_sr[0] is the previous sample; r_sr[IN_DIM-1] / r_sr[IN_DIM] sit one row up.
  logic [DATA_W-1:0] r_sr [IN_DIM+1];
  logic              w_last_col, w_last_row;
  logic              w_win_valid, w_win_last;

  always_comb begin
    w_last_col  = (r_col == CntW'(IN_DIM - 1));
    w_last_row  = (r_row == CntW'(IN_DIM - 1));
    // Row 0 / column 0 windows would read stale line-buffer data; never emit them.
    w_win_valid = in_valid && (r_row != '0) && (r_col != '0);
    w_win_last  = w_win_valid && w_last_row && w_last_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= IN_DIM; i++) begin
        r_sr[i] <= '0;
      end
    end else if (in_valid) begin
      r_sr[0] <= In_OFM;
      for (int unsigned i = 1; i <= IN_DIM; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  pool_reduce4 #(
    .DATA_W (DATA_W)
  ) u_reduce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_win_valid),
    .i_last  (w_win_last),
    .i_a     (r_sr[IN_DIM]),
    .i_b     (r_sr[IN_DIM-1]),
    .i_c     (r_sr[0]),
    .i_d     (In_OFM),
    .o_valid (out_valid),
    .o_last  (frame_done),
    .o_data  (Out_Pool)
  );

endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream: a driver pushes expected windows computed from a
// frame image into a queue; a monitor pops and compares whenever out_valid is high.
module tb_pool2x2_stream;
  import pool_pkg::*;

  localparam int unsigned W = POOL_DATA_W;
  localparam int unsigned D = POOL_IN_DIM;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] In_OFM;
  logic         out_valid;
  logic [W-1:0] Out_Pool;
  logic         frame_done;

  exp_t         exp_q[$];
  logic [W-1:0] cap_q[$];
  logic [W-1:0] img [D][D];
  int           m_row, m_col;
  int           n_cmp, n_err;
  logic [W-1:0] ones;

  pool2x2_stream u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .In_OFM     (In_OFM),
    .out_valid  (out_valid),
    .Out_Pool   (Out_Pool),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_pool(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
`ifdef POOL_AVG_EN
    logic [W+1:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return W'(s / 4);
`else
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  // Present one accepted sample and record the window it completes.
  task automatic send(input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    In_OFM   = d;
    img[m_row][m_col] = d;
    if (m_row > 0 && m_col > 0) begin
      e.data = ref_pool(img[m_row-1][m_col-1], img[m_row-1][m_col], img[m_row][m_col-1], d);
      e.last = (m_row == D - 1) && (m_col == D - 1);
      exp_q.push_back(e);
    end
    if (m_col == D - 1) begin
      m_col = 0;
      m_row = (m_row == D - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  // Idle cycles carry junk data that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      In_OFM   = W'({$urandom(), $urandom()});
    end
  endtask

  task automatic drain(input string name);
    int k;
    idle(1);
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return ones;
      1:       return W'($urandom_range(0, 3));
      default: return W'({$urandom(), $urandom()});
    endcase
  endfunction

  // Monitor: compare every presented output against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %0h, expected no output", Out_Pool);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(Out_Pool), 64'(e.data));
        check("frame_done", 64'(frame_done), 64'(e.last));
        cap_q.push_back(Out_Pool);
      end
    end else begin
      check("idle_data", 64'(Out_Pool), 64'd0);
      check("idle_done", 64'(frame_done), 64'd0);
    end
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    m_row    = 0;
    m_col    = 0;
    ones     = '1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    In_OFM   = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pool", 64'(Out_Pool), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;

    // Ramp 0..24, continuous; also compare the captured values with the closed form.
    cap_q.delete();
    for (int k = 0; k < int'(D * D); k++) send(W'(k));
    drain("drain_ramp");
    check("ramp_count", 64'(cap_q.size()), 64'((D - 1) * (D - 1)));
    for (int r = 1; r < int'(D); r++) begin
      for (int c = 1; c < int'(D); c++) begin
        if (cap_q.size() != 0) begin
`ifdef POOL_AVG_EN
          check("ramp_value", 64'(cap_q.pop_front()), 64'(int'(D) * r + c - 3));
`else
          check("ramp_value", 64'(cap_q.pop_front()), 64'(int'(D) * r + c));
`endif
        end
      end
    end

    // Same ramp with in_valid toggling every cycle.
    for (int k = 0; k < int'(D * D); k++) begin
      send(W'(k));
      idle(1);
    end
    drain("drain_toggle");

    // Single all-ones sample in a zero frame.
    for (int k = 0; k < int'(D * D); k++) send((k == 12) ? ones : '0);
    drain("drain_spike");

    // Partial frame, reset, then a full frame with no stale output.
    for (int k = 0; k < 10; k++) send(W'(k));
    idle(3);
    pulse_reset();
    for (int k = 0; k < int'(D * D); k++) send(W'(k));
    drain("drain_reset");

    // Back-to-back frames with no idle cycle between them.
    for (int k = 0; k < int'(D * D); k++) send(W'(k));
    for (int k = 0; k < int'(D * D); k++) send(W'(100 + k));
    drain("drain_b2b");

    // All-ones frame: no overflow in either pooling mode.
    for (int k = 0; k < int'(D * D); k++) send(ones);
    drain("drain_ones");

    // Random data with random gaps, plus one mid-frame reset.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < int'(D * D); k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(rand_sample());
        if (f == 4 && k == 13) begin
          idle(3);
          pulse_reset();
          break;
        end
      end
    end
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
